// File: rtl/fifo_flops_ext.sv
// Flop-based FWFT FIFO with occupancy count, almost-full/empty flags, overflow/underflow flags
// and non-power-of-two depth. Define FIFO_STICKY_ERR_EN to make ovf/udf sticky until err_clr or rst.
module fifo_flops_ext #(
    parameter int depth  = 8,
    parameter int bits   = 16,
    parameter int AF_LVL = depth - 2,
    parameter int AE_LVL = 1,
    parameter int CW     = $clog2(depth + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [bits-1:0] Din,
    input  logic            push,
    input  logic            pop,
    output logic [bits-1:0] Dout,
    output logic            pndng,
    output logic            full,
    output logic            almost_full,
    output logic            almost_empty,
    output logic [CW-1:0]   count,
    output logic            ovf,
    output logic            udf,
    input  logic            err_clr
);

    localparam int PW = $clog2(depth);

    logic [bits-1:0] mem [depth];

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          pndng_q, pndng_d;
    logic          full_q, full_d;
    logic          almost_full_q, almost_full_d;
    logic          almost_empty_q, almost_empty_d;
    logic          ovf_q, ovf_d;
    logic          udf_q, udf_d;

    logic push_acc, pop_acc, ovf_ev, udf_ev;

    always_comb begin
        pop_acc  = pop & pndng_q;
        // A full FIFO still takes a push when the head is leaving in the same cycle.
        push_acc = push & (~full_q | pop_acc);
        ovf_ev   = push & full_q & ~pop_acc;
        udf_ev   = pop & ~pndng_q;

        wr_ptr_d = wr_ptr_q;
        if (push_acc) begin
            wr_ptr_d = (wr_ptr_q == PW'(depth - 1)) ? '0 : wr_ptr_q + PW'(1);
        end

        rd_ptr_d = rd_ptr_q;
        if (pop_acc) begin
            rd_ptr_d = (rd_ptr_q == PW'(depth - 1)) ? '0 : rd_ptr_q + PW'(1);
        end

        count_d        = count_q + CW'(push_acc) - CW'(pop_acc);
        pndng_d        = (count_d != '0);
        full_d         = (count_d == CW'(depth));
        almost_full_d  = (count_d >= CW'(AF_LVL));
        almost_empty_d = (count_d <= CW'(AE_LVL));

`ifdef FIFO_STICKY_ERR_EN
        // A fresh error in the clearing cycle keeps the flag set.
        ovf_d = ovf_ev | (ovf_q & ~err_clr);
        udf_d = udf_ev | (udf_q & ~err_clr);
`else
        ovf_d = ovf_ev;
        udf_d = udf_ev;
`endif
    end

`ifndef FIFO_STICKY_ERR_EN
    logic unused_err_clr;
    assign unused_err_clr = err_clr;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            pndng_q        <= 1'b0;
            full_q         <= 1'b0;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            ovf_q          <= 1'b0;
            udf_q          <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            pndng_q        <= pndng_d;
            full_q         <= full_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            ovf_q          <= ovf_d;
            udf_q          <= udf_d;
        end
    end

    // Storage is deliberately not reset; only the write itself is suppressed during rst.
    always_ff @(posedge clk) begin
        if (!rst && push_acc) begin
            mem[wr_ptr_q] <= Din;
        end
    end

    assign Dout         = pndng_q ? mem[rd_ptr_q] : '0;
    assign pndng        = pndng_q;
    assign full         = full_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign count        = count_q;
    assign ovf          = ovf_q;
    assign udf          = udf_q;

endmodule

// File: tb/tb_fifo_flops_ext.sv
// Self-checking bench for fifo_flops_ext (depth=8, bits=16, AF_LVL=6, AE_LVL=1):
// directed vector table, hand-written corner sequences, and randomized traffic against a queue model.
module tb_fifo_flops_ext;

    localparam int DEPTH = 8;
    localparam int BITS  = 16;
    localparam int CW    = $clog2(DEPTH + 1);

    logic            clk = 1'b0;
    logic            rst, push, pop, err_clr;
    logic [BITS-1:0] Din, Dout;
    logic            pndng, full, almost_full, almost_empty, ovf, udf;
    logic [CW-1:0]   count;

    int checks = 0;
    int errors = 0;

    fifo_flops_ext #(.depth(DEPTH), .bits(BITS), .AF_LVL(6), .AE_LVL(1)) dut (
        .clk(clk), .rst(rst), .Din(Din), .push(push), .pop(pop), .Dout(Dout),
        .pndng(pndng), .full(full), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .ovf(ovf), .udf(udf), .err_clr(err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        push;
        logic        pop;
        logic        clr;
        logic [15:0] din;
        int          exp_count;
        logic [15:0] exp_dout;
        logic        exp_ovf;
        logic        exp_udf;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic p, input logic q, input logic c, input logic [15:0] d,
                                input int ec, input logic [15:0] ed, input logic eo, input logic eu);
        vec_t v;
        v.push = p; v.pop = q; v.clr = c; v.din = d;
        v.exp_count = ec; v.exp_dout = ed; v.exp_ovf = eo; v.exp_udf = eu;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Flags are checked against the occupancy rules, not against any DUT signal.
    task automatic chk_state(input string tag, input int ec, input logic [15:0] ed,
                             input logic eo, input logic eu);
        chk({tag, ".count"}, 32'(count), 32'(ec));
        chk({tag, ".Dout"}, 32'(Dout), 32'(ed));
        chk({tag, ".pndng"}, 32'(pndng), 32'(ec != 0));
        chk({tag, ".full"}, 32'(full), 32'(ec == DEPTH));
        chk({tag, ".almost_full"}, 32'(almost_full), 32'(ec >= 6));
        chk({tag, ".almost_empty"}, 32'(almost_empty), 32'(ec <= 1));
        chk({tag, ".ovf"}, 32'(ovf), 32'(eo));
        chk({tag, ".udf"}, 32'(udf), 32'(eu));
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic r, input logic p, input logic q, input logic c, input logic [15:0] d);
        rst = r; push = p; pop = q; err_clr = c; Din = d;
    endtask

    task automatic do_reset;
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        step();
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
    endtask

    logic [15:0] q_model[$];
    logic        m_ovf, m_udf;

    initial begin
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0);
        step();
        step();
        chk_state("reset", 0, 16'h0, 1'b0, 1'b0);
        $display("txn reset: count=%0d Dout=%h", count, Dout);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);

        // Directed table: fill, overflow, drain, underflow, push+pop on empty and full.
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 0, 16'(i), i, 16'h0001, 0, 0));
        vecs.push_back(mk(1, 0, 0, 16'hDEAD, 8, 16'h0001, 1, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, (k == 1), 16'h0, 8 - k, (k < 8) ? 16'(k + 1) : 16'h0, 0, 0));
        vecs.push_back(mk(0, 1, 0, 16'h0, 0, 16'h0, 0, 1));
        vecs.push_back(mk(1, 1, 1, 16'h0100, 1, 16'h0100, 0, 1));
        vecs.push_back(mk(0, 1, 1, 16'h0, 0, 16'h0, 0, 0));
        for (int i = 1; i <= 8; i++) vecs.push_back(mk(1, 0, 0, 16'(16'h10 + i), i, 16'h0011, 0, 0));
        vecs.push_back(mk(1, 1, 0, 16'h00AA, 8, 16'h0012, 0, 0));
        for (int k = 1; k <= 8; k++)
            vecs.push_back(mk(0, 1, 0, 16'h0, 8 - k,
                              (k <= 6) ? 16'(16'h12 + k) : ((k == 7) ? 16'h00AA : 16'h0), 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            drive(1'b0, vecs[i].push, vecs[i].pop, vecs[i].clr, vecs[i].din);
            step();
            $display("txn vec%0d: push=%b pop=%b din=%h -> count=%0d Dout=%h ovf=%b udf=%b",
                     i, vecs[i].push, vecs[i].pop, vecs[i].din, count, Dout, ovf, udf);
            chk_state($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_dout,
                      vecs[i].exp_ovf, vecs[i].exp_udf);
        end

        // Reset mid-fill at count=4 with a push in the reset cycle.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0A00 + i));
            step();
        end
        chk_state("midfill", 4, 16'h0A00, 1'b0, 1'b0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 16'hBEEF);
        step();
        $display("txn rst-midfill: count=%0d Dout=%h", count, Dout);
        chk_state("rst_midfill", 0, 16'h0, 1'b0, 1'b0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'h5555);
        step();
        $display("txn push-after-rst: count=%0d Dout=%h", count, Dout);
        chk_state("after_rst", 1, 16'h5555, 1'b0, 1'b0);

        // Overflow hold/pulse behaviour followed by err_clr.
        do_reset();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b1, 1'b0, 1'b0, 16'(16'h0C00 + i));
            step();
        end
        drive(1'b0, 1'b1, 1'b0, 1'b0, 16'hDEAD);
        step();
        $display("txn ovf: count=%0d ovf=%b", count, ovf);
        chk_state("ovf_set", 8, 16'h0C00, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0);
        for (int i = 0; i < 5; i++) begin
            step();
            $display("txn idle%0d: ovf=%b", i, ovf);
`ifdef FIFO_STICKY_ERR_EN
            chk_state($sformatf("ovf_idle%0d", i), 8, 16'h0C00, 1'b1, 1'b0);
`else
            chk_state($sformatf("ovf_idle%0d", i), 8, 16'h0C00, 1'b0, 1'b0);
`endif
        end
        drive(1'b0, 1'b0, 1'b0, 1'b1, 16'h0);
        step();
        $display("txn err_clr: ovf=%b", ovf);
        chk_state("ovf_clr", 8, 16'h0C00, 1'b0, 1'b0);

        // Randomized traffic against a queue model; push bias rotates to visit full and empty.
        do_reset();
        q_model.delete();
        m_ovf = 1'b0;
        m_udf = 1'b0;
        for (int i = 0; i < 600; i++) begin
            int   bias;
            logic p, q, c, pa, qa, oe, ue;
            logic [15:0] d;
            bias = (i / 60) % 3 == 0 ? 80 : ((i / 60) % 3 == 1 ? 50 : 20);
            p = ($urandom_range(99) < bias);
            q = ($urandom_range(99) < 50);
            c = ($urandom_range(99) < 10);
            d = 16'($urandom);
            qa = q && (q_model.size() != 0);
            pa = p && (q_model.size() < DEPTH || qa);
            oe = p && (q_model.size() == DEPTH) && !qa;
            ue = q && (q_model.size() == 0);
            if (qa) void'(q_model.pop_front());
            if (pa) q_model.push_back(d);
`ifdef FIFO_STICKY_ERR_EN
            m_ovf = oe | (m_ovf & ~c);
            m_udf = ue | (m_udf & ~c);
`else
            m_ovf = oe;
            m_udf = ue;
`endif
            drive(1'b0, p, q, c, d);
            step();
            $display("txn rnd%0d: push=%b pop=%b din=%h -> count=%0d Dout=%h", i, p, q, d, count, Dout);
            chk_state($sformatf("rnd%0d", i), q_model.size(),
                      (q_model.size() != 0) ? q_model[0] : 16'h0, m_ovf, m_udf);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_flops_ext.md
Name: fifo_flops_ext

Overview:
- Parametrised successor to the team's flop-based FIFO.
- Keeps the same push/pop/pndng/full contract and port names.
- Adds an occupancy count, programmable almost-full/almost-empty flags, overflow/underflow detection, and depth values that are not powers of two.
- Sits between a producer driven through the fifo interface and a consumer, as a drop-in DUT for the existing driver/checker/scoreboard environment.

Parameters:
- depth, 8, number of entries; any integer >= 2 (need not be a power of two).
- bits, 16, data width in bits.
- AF_LVL, depth-2, almost_full asserts when count >= AF_LVL; legal range 1..depth.
- AE_LVL, 1, almost_empty asserts when count <= AE_LVL; legal range 0..depth-1.
- CW, $clog2(depth+1), width of count (derived; not to be overridden).

Ports:
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- Din, input, bits, write data; sampled when push=1.
- push, input, 1, write request.
- pop, input, 1, read request; removes the head entry.
- Dout, output, bits, head entry (first-word-fall-through).
- pndng, output, 1, FIFO non-empty (count != 0).
- full, output, 1, count == depth.
- almost_full, output, 1, count >= AF_LVL.
- almost_empty, output, 1, count <= AE_LVL.
- count, output, CW, current occupancy, 0..depth.
- ovf, output, 1, overflow indication.
- udf, output, 1, underflow indication.
- err_clr, input, 1, clears sticky errors; ignored without FIFO_STICKY_ERR_EN.

Behaviour:
- Clocking and reset:
  - Single clock domain.
  - rst is synchronous, active-high, and has priority over push/pop in the same cycle.
- Reset values: count=0, pndng=0, full=0, almost_full=0, almost_empty=1, ovf=0, udf=0, Dout=0, rd_ptr=wr_ptr=0.
  - Storage array contents are not reset.
- Storage and pointers:
  - depth x bits flop array.
  - wr_ptr and rd_ptr each wrap from depth-1 to 0 (explicit compare, no power-of-two masking).
- Accepted operations:
  - Push is accepted iff push=1 and (full=0 or pop accepted in the same cycle).
  - Pop is accepted iff pop=1 and pndng=1.
- Effect of an accepted push: mem[wr_ptr] <= Din, wr_ptr advances.
- Effect of an accepted pop: rd_ptr advances.
- count update: count_next = count + push_acc - pop_acc.
  - All flags are registered and derived from count_next, so they are valid the cycle after the triggering edge.
- Dout:
  - Combinational mux of mem[rd_ptr] when pndng=1; 0 when empty.
  - Latency: push into an empty FIFO gives pndng=1 and Dout=Din at the next cycle.
- Simultaneous events:
  - push+pop when full: both accepted; count stays at depth; no ovf.
  - push+pop when empty: push accepted; pop rejected with udf; count becomes 1.
  - push+pop otherwise: both accepted; count unchanged; pointers both advance.
- Error conditions:
  - Overflow: push=1, full=1, pop not accepted. Din is dropped and contents are unchanged.
  - Underflow: pop=1, pndng=0. No state change apart from the error flag.
- ovf/udf timing: asserted on the cycle after the offending edge (registered).
- Reset mid-operation: any stored data is discarded, all outputs return to reset values at the next edge, and a push in the reset cycle is ignored.

Optional Feature:
- Macro: FIFO_STICKY_ERR_EN.
- Defined:
  - ovf/udf are sticky; once set, they hold until err_clr=1 or rst.
  - err_clr clears at the next edge.
  - If a new error and err_clr occur in the same cycle, the new error wins (flag stays 1).
- Undefined:
  - ovf/udf are single-cycle pulses, high for exactly the one cycle after each offending edge.
  - err_clr is unconnected internally.

Test Plan (depth=8, bits=16, AF_LVL=6, AE_LVL=1):
- Reset, then push 0x0001..0x0008 on consecutive cycles -> count 1..8; almost_empty drops when count=2; almost_full rises when count=6; full=1 when count=8; Dout=0x0001 throughout.
- From full, push 0xDEAD with pop=0 -> ovf=1 next cycle; count stays 8; then popping all 8 returns 0x0001..0x0008 in order; 0xDEAD is never seen.
- From empty, pop=1 -> udf=1 next cycle; count=0; pndng=0; Dout=0.
- Simultaneous push+pop while empty and while full:
  - Empty case: count becomes 1 with udf=1.
  - Full case: count stays 8 with no ovf, and the new word appears after the 7 older entries.
- Wrap-around: stream 20 words with interleaved push/pop keeping count between 2 and 5 -> output order matches input exactly; pointers wrap past entry 7 without loss.
- With FIFO_STICKY_ERR_EN: trigger ovf, idle 5 cycles -> ovf still 1; err_clr=1 -> ovf=0 next cycle; assert rst mid-fill at count=4 -> all outputs at reset values next cycle.
